// File: rtl/regfile_pkg.sv
// Shared types and defaults for the register-file controller.
// Holds the sequencer state encoding and the default bank geometry.
package regfile_pkg;

    localparam int DATAWIDTH_DEF = 32;
    localparam int DATADEPTH_DEF = 32;

    typedef enum logic [1:0] {
        INIT,
        CLEAR,
        RUN
    } regfileState_t;

endpackage

// File: rtl/regfile_controller_if.sv
// Pipeline and bank signals of the register-file controller.
// master: the controller; slave: pipeline plus bank around it.
interface regfile_controller_if #(
    parameter int DATAWIDTH = 32,
    parameter int ADDRWIDTH = 5
);
    logic                 wbValid;
    logic [ADDRWIDTH-1:0] wbAddress;
    logic [DATAWIDTH-1:0] wbData;
    logic                 clearReq;
    logic [ADDRWIDTH-1:0] rdAddressA;
    logic [ADDRWIDTH-1:0] rdAddressB;
    logic [DATAWIDTH-1:0] rdDataA;
    logic [DATAWIDTH-1:0] rdDataB;
    logic                 ready;
    logic                 writeDropped;
    logic                 bankWriteEnable;
    logic [ADDRWIDTH-1:0] bankWriteAddress;
    logic [DATAWIDTH-1:0] bankWriteData;
    logic [ADDRWIDTH-1:0] bankReadAddressA;
    logic [ADDRWIDTH-1:0] bankReadAddressB;
    logic [DATAWIDTH-1:0] bankReadDataA;
    logic [DATAWIDTH-1:0] bankReadDataB;

    modport master (
        input  wbValid, wbAddress, wbData, clearReq,
        input  rdAddressA, rdAddressB,
        input  bankReadDataA, bankReadDataB,
        output rdDataA, rdDataB, ready, writeDropped,
        output bankWriteEnable, bankWriteAddress,
        output bankWriteData,
        output bankReadAddressA, bankReadAddressB
    );

    modport slave (
        output wbValid, wbAddress, wbData, clearReq,
        output rdAddressA, rdAddressB,
        output bankReadDataA, bankReadDataB,
        input  rdDataA, rdDataB, ready, writeDropped,
        input  bankWriteEnable, bankWriteAddress,
        input  bankWriteData,
        input  bankReadAddressA, bankReadAddressB
    );

endinterface

// File: rtl/regfile_bypass.sv
// One read port: registered zero/forward flags and output mux.
// Ports: clk, reset_n, i_run, i_rdAddress, i_write*, i_bankReadData, o_rdData.
module regfile_bypass #(
    parameter int DATAWIDTH = 32,
    parameter int ADDRWIDTH = 5,
    parameter int ZEROREG   = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_run,
    input  logic [ADDRWIDTH-1:0] i_rdAddress,
    input  logic                 i_writeEnable,
    input  logic [ADDRWIDTH-1:0] i_writeAddress,
    input  logic [DATAWIDTH-1:0] i_writeData,
    input  logic [DATAWIDTH-1:0] i_bankReadData,
    output logic [DATAWIDTH-1:0] o_rdData
);

    logic                 r_zero;
    logic                 r_fwd;
    logic [DATAWIDTH-1:0] r_fwdData;
    logic                 w_zero;
    logic                 w_fwd;

    assign w_zero = !i_run ||
                    ((ZEROREG != 0) && (i_rdAddress == '0));
    // Bank returns old data when read and write collide.
    assign w_fwd = i_writeEnable &&
                   (i_writeAddress == i_rdAddress);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_zero    <= 1'b1;
            r_fwd     <= 1'b0;
            r_fwdData <= '0;
        end else begin
            r_zero    <= w_zero;
            r_fwd     <= w_fwd;
            r_fwdData <= i_writeData;
        end
    end

    assign o_rdData = r_zero ? '0 :
                      r_fwd  ? r_fwdData :
                               i_bankReadData;

endmodule

// File: rtl/regfile_controller.sv
// Register-file bank sequencer: zero sweep, write arbitration, bypass.
// Ports: clk, reset_n, bus (master: pipeline and bank signals).
module regfile_controller
    import regfile_pkg::*;
#(
    parameter int DATAWIDTH = DATAWIDTH_DEF,
    parameter int DATADEPTH = DATADEPTH_DEF,
    parameter int ZEROREG   = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    regfile_controller_if.master  bus
);

    localparam int ADDRWIDTH = $clog2(DATADEPTH);
    localparam logic [ADDRWIDTH-1:0] LAST =
        ADDRWIDTH'(DATADEPTH - 1);

    regfileState_t        r_state;
    regfileState_t        w_stateNext;
    logic [ADDRWIDTH-1:0] r_count;
    logic [ADDRWIDTH-1:0] w_countNext;
    logic                 r_ready;
    logic                 r_writeDropped;
    logic                 w_we;
    logic [ADDRWIDTH-1:0] w_wa;
    logic [DATAWIDTH-1:0] w_wd;
    logic                 w_run;

    always_comb begin
        w_stateNext = r_state;
        w_countNext = r_count;
        w_we        = 1'b0;
        w_wa        = bus.wbAddress;
        w_wd        = bus.wbData;
        unique case (r_state)
            INIT: begin
                w_stateNext = CLEAR;
            end
            CLEAR: begin
                w_we = 1'b1;
                w_wa = r_count;
                w_wd = '0;
                // Counter parks at LAST; reset on next sweep entry.
                if (r_count == LAST) begin
                    w_stateNext = RUN;
                end else begin
                    w_countNext = r_count + 1'b1;
                end
            end
            RUN: begin
                w_we = bus.wbValid &&
                       !((ZEROREG != 0) &&
                         (bus.wbAddress == '0));
                if (bus.clearReq) begin
                    w_stateNext = CLEAR;
                    w_countNext = '0;
                end
            end
            default: begin
                w_stateNext = INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= INIT;
            r_count        <= '0;
            r_ready        <= 1'b0;
            r_writeDropped <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_count <= w_countNext;
            r_ready <= (w_stateNext == RUN);
            if (bus.wbValid && (r_state != RUN)) begin
                r_writeDropped <= 1'b1;
            end
        end
    end

    assign w_run = (r_state == RUN);

    assign bus.ready            = r_ready;
    assign bus.writeDropped     = r_writeDropped;
    assign bus.bankWriteEnable  = w_we;
    assign bus.bankWriteAddress = w_wa;
    assign bus.bankWriteData    = w_wd;
    assign bus.bankReadAddressA = bus.rdAddressA;
    assign bus.bankReadAddressB = bus.rdAddressB;

    regfile_bypass #(
        .DATAWIDTH (DATAWIDTH),
        .ADDRWIDTH (ADDRWIDTH),
        .ZEROREG   (ZEROREG)
    ) u_bypassA (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_run          (w_run),
        .i_rdAddress    (bus.rdAddressA),
        .i_writeEnable  (w_we),
        .i_writeAddress (w_wa),
        .i_writeData    (w_wd),
        .i_bankReadData (bus.bankReadDataA),
        .o_rdData       (bus.rdDataA)
    );

    regfile_bypass #(
        .DATAWIDTH (DATAWIDTH),
        .ADDRWIDTH (ADDRWIDTH),
        .ZEROREG   (ZEROREG)
    ) u_bypassB (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_run          (w_run),
        .i_rdAddress    (bus.rdAddressB),
        .i_writeEnable  (w_we),
        .i_writeAddress (w_wa),
        .i_writeData    (w_wd),
        .i_bankReadData (bus.bankReadDataB),
        .o_rdData       (bus.rdDataB)
    );

endmodule

// File: tb/tb_regfile_controller.sv
// Directed bench for regfile_controller with a 1-cycle-read bank model.
// Vector table for RUN traffic plus sweep/clear/reset sequences.
module tb_regfile_controller;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    regfile_controller_if #(.DATAWIDTH(32), .ADDRWIDTH(5)) bus ();

    regfile_controller #(
        .DATAWIDTH (32),
        .DATADEPTH (32),
        .ZEROREG   (1)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Bank: write lands at the edge, read returns pre-edge contents.
    logic [31:0] mem [32] = '{default: 32'hBADBAD00};

    always @(posedge clk) begin
        if (bus.bankWriteEnable)
            mem[bus.bankWriteAddress] <= bus.bankWriteData;
        bus.bankReadDataA <= mem[bus.bankReadAddressA];
        bus.bankReadDataB <= mem[bus.bankReadAddressB];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    // Called just after the edge that enters CLEAR.
    task automatic sweep(input int hitk);
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            bus.clearReq  = 1'b0;
            bus.wbValid   = (k == hitk);
            bus.wbAddress = 5'd9;
            bus.wbData    = 32'hA5A5A5A5;
            #1;
            chk("sweep_we", 32'(bus.bankWriteEnable), 32'd1);
            chk("sweep_addr", 32'(bus.bankWriteAddress), 32'(k));
            chk("sweep_data", bus.bankWriteData, 32'h0);
            chk("sweep_ready", 32'(bus.ready), 32'd0);
            if (k > 0)
                chk("sweep_rdA", bus.rdDataA, 32'h0);
            @(posedge clk);
        end
        bus.wbValid = 1'b0;
        #1;
        chk("sweep_done_ready", 32'(bus.ready), 32'd1);
    endtask

    typedef struct {
        logic        wbv;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic        ewe;
        logic [31:0] ea;
        logic [31:0] eb;
    } vec_t;

    vec_t vecs [9];
    logic found;

    initial begin
        vecs[0] = '{1'b1, 5'd7,  32'hDEADBEEF, 5'd7,  5'd1,
                    1'b1, 32'hDEADBEEF, 32'h0};
        vecs[1] = '{1'b0, 5'd7,  32'h0,        5'd7,  5'd7,
                    1'b0, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 5'd0,  32'h00001234, 5'd7,  5'd0,
                    1'b0, 32'hDEADBEEF, 32'h0};
        vecs[3] = '{1'b1, 5'd5,  32'h11111111, 5'd5,  5'd0,
                    1'b1, 32'h11111111, 32'h0};
        vecs[4] = '{1'b1, 5'd5,  32'h22222222, 5'd5,  5'd5,
                    1'b1, 32'h22222222, 32'h22222222};
        vecs[5] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd7,
                    1'b0, 32'h22222222, 32'hDEADBEEF};
        vecs[6] = '{1'b1, 5'd31, 32'hCAFEF00D, 5'd31, 5'd0,
                    1'b1, 32'hCAFEF00D, 32'h0};
        vecs[7] = '{1'b1, 5'd30, 32'h00000001, 5'd31, 5'd30,
                    1'b1, 32'hCAFEF00D, 32'h00000001};
        vecs[8] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd30,
                    1'b0, 32'h0, 32'h00000001};

        bus.wbValid    = 1'b0;
        bus.wbAddress  = '0;
        bus.wbData     = '0;
        bus.clearReq   = 1'b0;
        bus.rdAddressA = 5'd5;
        bus.rdAddressB = 5'd0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(bus.ready), 32'd0);
        chk("rst_wd", 32'(bus.writeDropped), 32'd0);
        chk("rst_we", 32'(bus.bankWriteEnable), 32'd0);
        chk("rst_rdA", bus.rdDataA, 32'h0);
        chk("rst_rdB", bus.rdDataB, 32'h0);

        // Initial sweep
        reset_n = 1'b1;
        #1;
        chk("init_we", 32'(bus.bankWriteEnable), 32'd0);
        @(posedge clk);
        sweep(-1);
        chk("run_wd", 32'(bus.writeDropped), 32'd0);

        // RUN vectors
        foreach (vecs[i]) begin
            @(negedge clk);
            bus.wbValid    = vecs[i].wbv;
            bus.wbAddress  = vecs[i].wa;
            bus.wbData     = vecs[i].wd;
            bus.rdAddressA = vecs[i].ra;
            bus.rdAddressB = vecs[i].rb;
            #1;
            chk("vec_we", 32'(bus.bankWriteEnable), 32'(vecs[i].ewe));
            if (vecs[i].ewe) begin
                chk("vec_wa", 32'(bus.bankWriteAddress), 32'(vecs[i].wa));
                chk("vec_wdata", bus.bankWriteData, vecs[i].wd);
            end
            @(posedge clk);
            #1;
            chk("vec_rdA", bus.rdDataA, vecs[i].ea);
            chk("vec_rdB", bus.rdDataB, vecs[i].eb);
            chk("vec_ready", 32'(bus.ready), 32'd1);
        end
        bus.wbValid = 1'b0;
        chk("vec_wd", 32'(bus.writeDropped), 32'd0);

        // Write r3 then clear, with a dropped write mid-sweep
        @(negedge clk);
        bus.wbValid    = 1'b1;
        bus.wbAddress  = 5'd3;
        bus.wbData     = 32'h55;
        bus.rdAddressA = 5'd3;
        @(posedge clk);
        @(negedge clk);
        bus.wbValid  = 1'b0;
        bus.clearReq = 1'b1;
        #1;
        chk("clr_ready_pre", 32'(bus.ready), 32'd1);
        @(posedge clk);
        #1;
        chk("clr_ready_post", 32'(bus.ready), 32'd0);
        chk("clr_r3_bank", bus.rdDataA, 32'h55);
        sweep(4);
        chk("drop_wd", 32'(bus.writeDropped), 32'd1);
        @(negedge clk);
        bus.rdAddressA = 5'd9;
        bus.rdAddressB = 5'd3;
        @(posedge clk);
        #1;
        chk("drop_r9", bus.rdDataA, 32'h0);
        chk("clr_r3", bus.rdDataB, 32'h0);
        chk("drop_wd_sticky", 32'(bus.writeDropped), 32'd1);

        // Reset mid-sweep at counter 10
        @(negedge clk);
        bus.clearReq = 1'b1;
        @(posedge clk);
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            bus.clearReq = 1'b0;
            #1;
            if (bus.bankWriteEnable &&
                bus.bankWriteAddress == 5'd10) begin
                found = 1'b1;
                break;
            end
        end
        chk("find_cnt10", 32'(found), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("midrst_we", 32'(bus.bankWriteEnable), 32'd0);
        chk("midrst_ready", 32'(bus.ready), 32'd0);
        chk("midrst_wd", 32'(bus.writeDropped), 32'd0);
        chk("midrst_rdA", bus.rdDataA, 32'h0);
        chk("midrst_rdB", bus.rdDataB, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rel_we", 32'(bus.bankWriteEnable), 32'd0);
        @(posedge clk);
        sweep(-1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
